// File: rtl/register_file_banked.sv
// register_file_banked
//   Banked index register file for the CPU datapath. Holds NUM_BANKS banks of
//   NUM_REGS registers, each REG_WIDTH bits wide. Supports single-register and
//   even/odd pair access, an in-place increment with zero detect (ISZ/INC), a
//   bank-select register, optional same-cycle write-to-read forwarding and a
//   background sequencer that zeroes every register, one per cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   bankSelWe/bankSelDin     load the bank-select register at the edge
//   bankSel                  current bank index
//   regWe/regAddr/regDin     single-register write; regAddr also drives regDout
//   pairWe/pairAddr/pairDin  pair write (pairAddr forced even); pairAddr drives pairDout
//   incEn/incAddr            increment register incAddr
//   incZero                  incremented value of regs[incAddr] would be zero
//   clrReq                   start background clear of all banks
//   busy, clrDone            clear in progress / one-cycle completion pulse
//   regDout, pairDout        combinational reads from the current bank
module register_file_banked #(
  parameter int REG_WIDTH = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_BANKS = 2,
  parameter int BYPASS    = 0,
  localparam int AW = $clog2(NUM_REGS),
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bankSelWe,
  input  logic [BW-1:0]          bankSelDin,
  output logic [BW-1:0]          bankSel,
  input  logic                   regWe,
  input  logic [AW-1:0]          regAddr,
  input  logic [REG_WIDTH-1:0]   regDin,
  input  logic                   pairWe,
  input  logic [AW-1:0]          pairAddr,
  input  logic [2*REG_WIDTH-1:0] pairDin,
  input  logic                   incEn,
  input  logic [AW-1:0]          incAddr,
  output logic                   incZero,
  input  logic                   clrReq,
  output logic                   busy,
  output logic                   clrDone,
  output logic [REG_WIDTH-1:0]   regDout,
  output logic [2*REG_WIDTH-1:0] pairDout
);

  // Clear counter walks bank-major: upper BW bits select the bank, lower AW
  // bits the register. With a single bank the top bit simply stays zero.
  localparam int CW = BW + AW;
  localparam logic [CW-1:0] CLR_LAST = CW'(NUM_BANKS * NUM_REGS - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [REG_WIDTH-1:0] regs [NUM_BANKS][NUM_REGS];
  logic [0:0]           state;
  logic [CW-1:0]        clrCnt;

  // Committed write for this cycle: port A carries the clear step, the even
  // half of a pair, a single write or the increment; port B only carries the
  // odd half of a pair and always targets the current bank.
  logic                 wrEnA;
  logic [BW-1:0]        wrBankA;
  logic [AW-1:0]        wrAddrA;
  logic [REG_WIDTH-1:0] wrDataA;
  logic                 wrIsInc;
  logic                 wrEnB;
  logic [AW-1:0]        wrAddrB;
  logic [REG_WIDTH-1:0] wrDataB;

  logic [AW-1:0]        evenAddr;
  logic [AW-1:0]        oddAddr;
  logic [REG_WIDTH-1:0] curInc;
  logic [REG_WIDTH-1:0] incVal;
  logic                 fwdA;
  logic                 fwdB;

  function automatic logic [REG_WIDTH-1:0] inc_wrap(input logic [REG_WIDTH-1:0] v);
    return v + REG_WIDTH'(1);
  endfunction

  // Returns the stored value unless an enabled write port targets the address.
  function automatic logic [REG_WIDTH-1:0] fwd(
    input logic [AW-1:0]        a,
    input logic [REG_WIDTH-1:0] stored,
    input logic                 enA,
    input logic [AW-1:0]        aA,
    input logic [REG_WIDTH-1:0] dA,
    input logic                 enB,
    input logic [AW-1:0]        aB,
    input logic [REG_WIDTH-1:0] dB
  );
    if (enA && (aA == a)) return dA;
    if (enB && (aB == a)) return dB;
    return stored;
  endfunction

  assign busy     = (state == ST_CLEAR);
  assign evenAddr = pairAddr & ~AW'(1);
  assign oddAddr  = pairAddr | AW'(1);
  assign curInc   = regs[bankSel][incAddr];
  assign incVal   = inc_wrap(curInc);

  always_comb begin
    wrEnA   = 1'b0;
    wrBankA = bankSel;
    wrAddrA = regAddr;
    wrDataA = regDin;
    wrIsInc = 1'b0;
    wrEnB   = 1'b0;
    wrAddrB = oddAddr;
    wrDataB = pairDin[REG_WIDTH-1:0];
    if (busy) begin
      wrEnA   = 1'b1;
      wrBankA = clrCnt[CW-1:AW];
      wrAddrA = clrCnt[AW-1:0];
      wrDataA = '0;
    end else if (pairWe) begin
      wrEnA   = 1'b1;
      wrAddrA = evenAddr;
      wrDataA = pairDin[2*REG_WIDTH-1:REG_WIDTH];
      wrEnB   = 1'b1;
    end else if (regWe) begin
      wrEnA   = 1'b1;
    end else if (incEn) begin
      wrEnA   = 1'b1;
      wrAddrA = incAddr;
      wrDataA = incVal;
      wrIsInc = 1'b1;
    end
  end

  // Forwarding only applies to writes landing in the bank being read; a clear
  // step in another bank must not leak into the reads.
  assign fwdA = (BYPASS != 0) && wrEnA && (wrBankA == bankSel);
  assign fwdB = (BYPASS != 0) && wrEnB;

  assign regDout  = fwd(regAddr, regs[bankSel][regAddr], fwdA, wrAddrA, wrDataA,
                        fwdB, wrAddrB, wrDataB);
  assign pairDout = {fwd(evenAddr, regs[bankSel][evenAddr], fwdA, wrAddrA, wrDataA,
                         fwdB, wrAddrB, wrDataB),
                     fwd(oddAddr, regs[bankSel][oddAddr], fwdA, wrAddrA, wrDataA,
                         fwdB, wrAddrB, wrDataB)};
  // The increment's own result is excluded from forwarding here; otherwise
  // incZero would describe the value after the increment rather than its result.
  assign incZero  = &fwd(incAddr, curInc, fwdA && !wrIsInc, wrAddrA, wrDataA,
                         fwdB, wrAddrB, wrDataB);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          regs[b][r] <= '0;
        end
      end
      bankSel <= '0;
      state   <= ST_IDLE;
      clrCnt  <= '0;
      clrDone <= 1'b0;
    end else begin
      clrDone <= 1'b0;
      if (bankSelWe) bankSel <= (NUM_BANKS > 1) ? bankSelDin : '0;
      if (wrEnA) regs[wrBankA][wrAddrA] <= wrDataA;
      if (wrEnB) regs[bankSel][wrAddrB] <= wrDataB;
      case (state)
        ST_IDLE: begin
          if (clrReq) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clrCnt == CLR_LAST) begin
            state   <= ST_IDLE;
            clrCnt  <= '0;
            clrDone <= 1'b1;
          end else begin
            clrCnt <= clrCnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file_banked.sv
module tb_register_file_banked;

  typedef struct {
    logic       bsWe;
    logic       bsDin;
    logic       regWe;
    logic [3:0] regAddr;
    logic [3:0] regDin;
    logic       pairWe;
    logic [3:0] pairAddr;
    logic [7:0] pairDin;
    logic       incEn;
    logic [3:0] incAddr;
    logic [3:0] eReg;
    logic [7:0] ePair;
    logic       eZero;
    logic       eBank;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       bankSelWe;
  logic [0:0] bankSelDin;
  logic       regWe;
  logic [3:0] regAddr;
  logic [3:0] regDin;
  logic       pairWe;
  logic [3:0] pairAddr;
  logic [7:0] pairDin;
  logic       incEn;
  logic [3:0] incAddr;
  logic       clrReq;

  logic [0:0] bankSel,  bankSelB;
  logic       incZero,  incZeroB;
  logic       busy,     busyB;
  logic       clrDone,  clrDoneB;
  logic [3:0] regDout,  regDoutB;
  logic [7:0] pairDout, pairDoutB;

  int checks = 0;
  int errors = 0;
  vec_t tv[$];

  register_file_banked #(.REG_WIDTH(4), .NUM_REGS(16), .NUM_BANKS(2), .BYPASS(0)) dut (
    .clk(clk), .rst(rst), .bankSelWe(bankSelWe), .bankSelDin(bankSelDin), .bankSel(bankSel),
    .regWe(regWe), .regAddr(regAddr), .regDin(regDin), .pairWe(pairWe), .pairAddr(pairAddr),
    .pairDin(pairDin), .incEn(incEn), .incAddr(incAddr), .incZero(incZero), .clrReq(clrReq),
    .busy(busy), .clrDone(clrDone), .regDout(regDout), .pairDout(pairDout)
  );

  register_file_banked #(.REG_WIDTH(4), .NUM_REGS(16), .NUM_BANKS(2), .BYPASS(1)) dutb (
    .clk(clk), .rst(rst), .bankSelWe(bankSelWe), .bankSelDin(bankSelDin), .bankSel(bankSelB),
    .regWe(regWe), .regAddr(regAddr), .regDin(regDin), .pairWe(pairWe), .pairAddr(pairAddr),
    .pairDin(pairDin), .incEn(incEn), .incAddr(incAddr), .incZero(incZeroB), .clrReq(clrReq),
    .busy(busyB), .clrDone(clrDoneB), .regDout(regDoutB), .pairDout(pairDoutB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(int bsWe, int bsDin, int rWe, int rA, int rD, int pWe, int pA,
                              int pD, int iEn, int iA, int eR, int eP, int eZ, int eB);
    vec_t v;
    v.bsWe = bsWe[0];  v.bsDin = bsDin[0];
    v.regWe = rWe[0];  v.regAddr = rA[3:0];  v.regDin = rD[3:0];
    v.pairWe = pWe[0]; v.pairAddr = pA[3:0]; v.pairDin = pD[7:0];
    v.incEn = iEn[0];  v.incAddr = iA[3:0];
    v.eReg = eR[3:0];  v.ePair = eP[7:0];    v.eZero = eZ[0]; v.eBank = eB[0];
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bankSelWe = v.bsWe;  bankSelDin = v.bsDin;
    regWe = v.regWe;     regAddr = v.regAddr;   regDin = v.regDin;
    pairWe = v.pairWe;   pairAddr = v.pairAddr; pairDin = v.pairDin;
    incEn = v.incEn;     incAddr = v.incAddr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_all();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); apply(mk(1, b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int p = 0; p < 8; p++) begin
        @(negedge clk); apply(mk(0, 0, 0, 0, 0, 1, 2 * p, 'h5A, 0, 0, 0, 0, 0, 0));
      end
    end
    @(negedge clk); apply(mk(0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("fill_b1_r3", regDout, 4'hA);
  endtask

  task automatic check_all_zero(input string tag);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); apply(mk(1, b, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int a = 0; a < 16; a++) begin
        @(negedge clk); apply(mk(0, 0, 0, a, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 chk($sformatf("%s_b%0d_r%0d", tag, b, a), regDout, 4'h0);
      end
    end
  endtask

  initial begin
    int cyc;
    int early;
    rst = 1'b1;
    clrReq = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //            bsWe bsD rWe rA rD  pWe pA pD    iEn iA  eReg ePair eZ eB
    tv.push_back(mk(0, 0,  0, 0, 0,   0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  0, 2, 0,   1, 3, 'hA5, 0, 0,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  0, 2, 0,   0, 3, 'h00, 0, 0,  'hA, 'hA5, 0, 0));
    tv.push_back(mk(0, 0,  1, 4, 'hF, 1, 4, 'h12, 0, 0,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  1, 8, 3,   0, 4, 'h00, 1, 2,  'h0, 'h12, 0, 0));
    tv.push_back(mk(0, 0,  0, 2, 0,   0, 8, 'h00, 0, 8,  'hA, 'h30, 0, 0));
    tv.push_back(mk(0, 0,  1, 7, 'hF, 0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  0, 7, 0,   0, 6, 'h00, 1, 7,  'hF, 'h0F, 1, 0));
    tv.push_back(mk(0, 0,  0, 7, 0,   0, 6, 'h00, 0, 7,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  1, 7, 3,   0, 6, 'h00, 0, 7,  'h0, 'h00, 0, 0));
    tv.push_back(mk(0, 0,  0, 7, 0,   0, 6, 'h00, 1, 7,  'h3, 'h03, 0, 0));
    tv.push_back(mk(0, 0,  0, 7, 0,   0, 6, 'h00, 0, 0,  'h4, 'h04, 0, 0));
    tv.push_back(mk(0, 0,  1, 0, 9,   0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 0));
    tv.push_back(mk(1, 1,  0, 0, 0,   0, 0, 'h00, 0, 0,  'h9, 'h90, 0, 0));
    tv.push_back(mk(0, 0,  0, 0, 0,   0, 2, 'h00, 0, 0,  'h0, 'h00, 0, 1));
    tv.push_back(mk(1, 0,  0, 0, 0,   0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 1));
    tv.push_back(mk(0, 0,  0, 0, 0,   0, 0, 'h00, 0, 0,  'h9, 'h90, 0, 0));
    tv.push_back(mk(1, 1,  1, 1, 'hC, 0, 0, 'h00, 0, 0,  'h0, 'h90, 0, 0));
    tv.push_back(mk(0, 0,  0, 1, 0,   0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 1));
    tv.push_back(mk(1, 0,  0, 1, 0,   0, 0, 'h00, 0, 0,  'h0, 'h00, 0, 1));
    tv.push_back(mk(0, 0,  0, 1, 0,   0, 0, 'h00, 0, 0,  'hC, 'h9C, 0, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_clrDone", clrDone, 0);
    chk("rst_bankSel", bankSel, 0);
    chk("rst_incZero", incZero, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      apply(tv[i]);
      #1;
      chk($sformatf("vec%0d_regDout", i), regDout, tv[i].eReg);
      chk($sformatf("vec%0d_pairDout", i), pairDout, tv[i].ePair);
      chk($sformatf("vec%0d_incZero", i), incZero, tv[i].eZero);
      chk($sformatf("vec%0d_bankSel", i), bankSel, tv[i].eBank);
    end

    // Forwarding: dutb sees the committed write in the same cycle, dut does not.
    @(negedge clk); apply(mk(0, 0, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("byp_reg_fwd", regDoutB, 4'h6);
    chk("nobyp_reg_old", regDout, 4'h2);
    @(negedge clk); apply(mk(0, 0, 0, 5, 0, 1, 10, 'h7E, 0, 0, 0, 0, 0, 0));
    #1 chk("byp_pair_fwd", pairDoutB, 8'h7E);
    chk("nobyp_pair_old", pairDout, 8'h00);
    chk("nobyp_reg_next", regDout, 4'h6);
    @(negedge clk); apply(mk(0, 0, 1, 11, 'hF, 0, 0, 0, 0, 11, 0, 0, 0, 0));
    #1 chk("byp_incZero_fwd", incZeroB, 1'b1);
    chk("nobyp_incZero_old", incZero, 1'b0);
    @(negedge clk); apply(mk(0, 0, 0, 11, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0));
    #1 chk("byp_inc_fwd", regDoutB, 4'h0);
    chk("byp_inc_zero", incZeroB, 1'b1);
    chk("nobyp_inc_old", regDout, 4'hF);

    // Full clear with writes and a second clrReq attempted while busy.
    fill_all();
    @(negedge clk); apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); clrReq = 1'b1;
    #1 chk("clr_busy_before", busy, 0);
    @(negedge clk);
    clrReq = 1'b0;
    apply(mk(0, 0, 1, 3, 'hF, 1, 8, 'hFF, 1, 4, 0, 0, 0, 0));
    cyc = 0;
    early = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (clrDone !== 1'b0) early++;
      cyc++;
      clrReq = (cyc == 5);
      @(negedge clk);
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clrReq = 1'b0;
    chk("clr_busy_cycles", cyc, 32);
    chk("clr_done_early", early, 0);
    chk("clr_done_pulse", clrDone, 1);
    @(negedge clk);
    chk("clr_done_single", clrDone, 0);
    chk("clr_busy_after", busy, 0);
    check_all_zero("clr");

    // Reset in the middle of a clear: sequence aborts without clrDone.
    fill_all();
    @(negedge clk); clrReq = 1'b1;
    @(negedge clk); clrReq = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    chk("rstclr_reached10", cyc, 10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstclr_busy", busy, 0);
    chk("rstclr_clrDone", clrDone, 0);
    chk("rstclr_bankSel", bankSel, 0);
    early = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (clrDone !== 1'b0 || busy !== 1'b0) early++;
    end
    chk("rstclr_no_done", early, 0);
    check_all_zero("rstclr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
